// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Signed width that covers -n..+n without overflow.
  function automatic int acc_width(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/ternary_popcount_diff.sv
// Combinational ternary slice sum: popcount(x&w&m) - popcount(x&~w&m).
module ternary_popcount_diff #(
  parameter  int CHUNK = 8,
  localparam int D_W   = $clog2(CHUNK) + 2
) (
  input  logic [CHUNK-1:0]      x,
  input  logic [CHUNK-1:0]      w,
  input  logic [CHUNK-1:0]      m,
  output logic signed [D_W-1:0] diff
);

  logic [CHUNK-1:0] pos_bits;
  logic [CHUNK-1:0] neg_bits;
  logic [D_W-1:0]   pos_cnt;
  logic [D_W-1:0]   neg_cnt;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bits
      assign pos_bits[gi] = x[gi] &  w[gi] & m[gi];
      assign neg_bits[gi] = x[gi] & ~w[gi] & m[gi];
    end
  endgenerate

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pos_cnt = pos_cnt + D_W'(pos_bits[i]);
      neg_cnt = neg_cnt + D_W'(neg_bits[i]);
    end
    diff = signed'(pos_cnt - neg_cnt);
  end

endmodule

// File: rtl/chunked_ternary_mac.sv
// Time-multiplexed ternary-weight MAC: accumulates N_INPUTS/CHUNK slices into a
// signed dot product and hands it to the neuron over a valid/ready handshake.
module chunked_ternary_mac
  import neuron_pkg::*;
#(
  parameter  int N_INPUTS = 64,
  parameter  int CHUNK    = 8,
  localparam int ACC_W    = acc_width(N_INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    chunk_valid,
  output logic                    chunk_ready,
  input  logic [CHUNK-1:0]        x_chunk,
  input  logic [CHUNK-1:0]        w_chunk,
  input  logic [CHUNK-1:0]        m_chunk,
  output logic                    busy,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [ACC_W-1:0] y_out
);

  localparam int NUM_CHUNKS = N_INPUTS / CHUNK;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int D_W        = $clog2(CHUNK) + 2;

  generate
    if ((N_INPUTS % CHUNK) != 0 || CHUNK > N_INPUTS) begin : g_bad_params
      $error("chunked_ternary_mac: CHUNK must divide N_INPUTS and not exceed it");
    end
  endgenerate

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] y_out_reg;
  logic signed [D_W-1:0]   partial;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    accept;
  logic                    last_accept;
  logic                    clear;

  ternary_popcount_diff #(.CHUNK(CHUNK)) u_diff (
    .x    (x_chunk),
    .w    (w_chunk),
    .m    (m_chunk),
    .diff (partial)
  );

  // Signed size cast sign-extends the slice sum to the accumulator width.
  assign acc_sum     = acc_reg + ACC_W'(partial);
  assign accept      = chunk_valid & chunk_ready;
  assign last_accept = accept && (cnt_reg == CNT_W'(NUM_CHUNKS - 1));
  assign clear       = start && ((state_reg == IDLE) || (state_reg == DONE && y_ready));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_accept) state_next = DONE;
      DONE:    if (y_ready) state_next = start ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    chunk_ready = (state_reg == ACCUM);
    busy        = (state_reg == ACCUM);
    y_valid     = (state_reg == DONE);
    y_out       = y_out_reg;
  end

  // y_out_reg only changes on the last slice, so it stays stable through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      y_out_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      acc_reg <= acc_sum;
      if (last_accept) begin
        cnt_reg   <= '0;
        y_out_reg <= acc_sum;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/chunked_ternary_mac.md
Name: chunked_ternary_mac

Overview:
- Time-multiplexed successor to the flat 64-input binary-weight popcount MAC feeding the LIF neuron membrane update.
- Consumes N_INPUTS spikes and weights as CHUNK-bit slices, one slice per accepted cycle.
- Adds a per-weight mask, so each weight is ternary (+1/−1/0).
- Accumulates the signed dot product and presents it to the neuron through a valid/ready handshake.

Parameters:
- N_INPUTS, 64, total synapses per dot product; power of two, ≥ CHUNK.
- CHUNK, 8, synapses per slice; power of two; must divide N_INPUTS.
- ACC_W, $clog2(N_INPUTS)+2, signed accumulator/output width. Derived; not overridden. Range covers −N_INPUTS..+N_INPUTS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new dot product; honoured only in IDLE, or in DONE with y_ready=1.
- chunk_valid  in  1  slice inputs valid this cycle.
- chunk_ready  out  1  block accepts a slice this cycle.
- x_chunk  in  CHUNK  input spikes for the current slice.
- w_chunk  in  CHUNK  weight sign: 1 = +1, 0 = −1.
- m_chunk  in  CHUNK  weight enable: 0 forces the weight to 0.
- busy  out  1  high in ACCUM.
- y_valid  out  1  result available.
- y_ready  in  1  consumer accepts the result.
- y_out  out  ACC_W  signed two's-complement dot product.

Behaviour:
- Reset (synchronous, active-high; wins over every other input, including mid-operation):
  - state=IDLE, accumulator=0, chunk counter=0.
  - chunk_ready=0, busy=0, y_valid=0, y_out=0.
  - A partially accumulated sum is discarded.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - chunk_ready=0.
  - start=1 → clear accumulator and counter; next state ACCUM.
  - chunk_valid is ignored.
- ACCUM:
  - chunk_ready=1, busy=1.
  - A slice is accepted on a cycle with chunk_valid & chunk_ready.
  - partial = popcount(x&w&m) − popcount(x&~w&m), range −CHUNK..+CHUNK, sign-extended to ACC_W.
  - acc ← acc + partial; counter increments.
  - chunk_valid=0 stalls with state held; no timeout.
  - start is ignored.
  - The accepting cycle with counter = N_INPUTS/CHUNK − 1 is the last slice:
    - y_out ← acc + partial, registered.
    - y_valid=1 from the next cycle.
    - Next state DONE.
  - Latency: y_valid rises exactly 1 cycle after the last slice is accepted. Total ≥ 1 + N_INPUTS/CHUNK cycles from start.
- DONE:
  - y_valid=1; y_out stable until the handshake completes.
  - chunk_ready=0.
  - y_ready=1 → y_valid drops next cycle.
    - start=0 in the same cycle → IDLE.
    - start=1 in the same cycle → ACCUM with accumulator cleared (back-to-back, no bubble).
  - start without y_ready is ignored; the result is never overwritten before consumption.
- y_out holds its last value after the handshake; it is meaningful only while y_valid=1.
- Arithmetic:
  - No saturation needed; the range is provably bounded.
  - Overflow must not occur for legal parameters. Verification asserts −N_INPUTS ≤ acc ≤ N_INPUTS.
- With N_INPUTS=64, CHUNK=64, m all ones, a single slice reproduces the legacy combinational result (ACC_W=8).
- Elaboration error if CHUNK does not divide N_INPUTS or CHUNK > N_INPUTS.

Decomposition:
- Shared package (neuron_pkg):
  - State enum (IDLE/ACCUM/DONE).
  - Helper function acc_width(n) = $clog2(n)+2.
  - Localparam NUM_CHUNKS = N_INPUTS/CHUNK, computed in the module from the parameters.
- One combinational sub-module, ternary_popcount_diff:
  - Parameter CHUNK; inputs x, w, m; output signed $clog2(CHUNK)+2 difference.
  - Reused by future parallel-lane variants.

Test Plan:
- Reset then start; 8 slices x=FF, w=FF, m=FF → y_valid 1 cycle after the 8th accept, y_out=+64.
- Same but w=00 → y_out=−64 (8'hC0). x=FF, w=F0, m=FF each slice → y_out=0.
- Mask test: x=FF, w=FF, m=0F each slice → y_out=+32. m=00 → 0.
- Stall: chunk_valid deasserted for 3 cycles between slices 4 and 5 → same y_out as without stalls, busy held.
- Back-pressure and back-to-back: hold y_ready=0 for 5 cycles → y_out stable, start ignored. Then y_ready=1 with start=1 → next cycle busy=1, second run (x=01 each slice, w=01, m=FF → +8) is correct.
- Reset asserted after slice 3, then new start with all slices zero → y_out=0, no residue.
